timer_multi_ch: RTL

Parametrised, multi-channel successor to the 8-bit timer register block. It merges a register file with the counting core, and generalises counter width, prescaler width and compare-channel count. New functions are up/down/up-down/one-shot modes, per-channel PWM outputs, a per-source interrupt enable mask and an overflow trigger pulse. It sits on the peripheral bus behind the same module_en/wr/addr strobe interface.

---
 rtl/timer_pkg.sv | 33 +++
 rtl/timer_tick_gen.sv | 48 ++++
 rtl/timer_multi_ch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, reset
// values, counting modes and CTRL bit positions.
package timer_pkg;

  // Register map (word addresses on the peripheral bus)
  localparam int ADDR_CTRL    = 'h00;
  localparam int ADDR_PSC     = 'h01;
  localparam int ADDR_STATUS  = 'h02;
  localparam int ADDR_INT_EN  = 'h03;
  localparam int ADDR_MIN     = 'h04;
  localparam int ADDR_MAX     = 'h05;
  localparam int ADDR_COUNT   = 'h06;
  localparam int ADDR_OUT_INV = 'h07;
  localparam int ADDR_CMP0    = 'h08;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_CLK_SEL = 3;

  // Reset values; MAX resets to all ones of whatever counter width is used
  localparam logic [3:0] CTRL_RST = 4'h0;
  localparam logic       MAX_RST_BIT = 1'b1;

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UPDOWN  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

endpackage

// File: rtl/timer_tick_gen.sv
// Count-enable generator: prescaled clk or a synchronised, edge-detected
// external tick, both gated by start.
module timer_tick_gen #(
  parameter int PSC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clk_sel,
  input  logic             psc_clr,
  input  logic [PSC_W-1:0] psc,
  input  logic             ext_tick,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;
  logic             ext_sync_p0;
  logic             ext_sync_p1;
  logic             ext_prev_p2;
  logic             ext_rise;

  // Prescaler counts 0..psc; parked at 0 while stopped or on a COUNT load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      psc_cnt <= '0;
    else if (!start || psc_clr || (psc_cnt == psc))
      psc_cnt <= '0;
    else
      psc_cnt <= psc_cnt + PSC_W'(1);
  end

  // Two-flop synchroniser followed by a history flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync_p0 <= 1'b0;
      ext_sync_p1 <= 1'b0;
      ext_prev_p2 <= 1'b0;
    end else begin
      ext_sync_p0 <= ext_tick;
      ext_sync_p1 <= ext_sync_p0;
      ext_prev_p2 <= ext_sync_p1;
    end
  end

  assign ext_rise = ext_sync_p1 & ~ext_prev_p2;
  assign tick     = start & (clk_sel ? ext_rise : (psc_cnt == psc));

endmodule

// File: rtl/timer_multi_ch.sv
// Multi-channel timer: register file, counter with four counting modes,
// compare channels with PWM outputs, masked interrupt and overflow trigger.
module timer_multi_ch
  import timer_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              module_en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [CNT_W-1:0]  wdata,
  output logic [CNT_W-1:0]  rdata,
  input  logic              ext_tick,
  output logic [NUM_CH-1:0] ch_out,
  output logic              irq,
  output logic              trig
);

  logic              start_r;
  mode_e             mode_r;
  logic              clk_sel_r;
  logic [PSC_W-1:0]  psc_r;
  logic [NUM_CH:0]   status_r;
  logic [NUM_CH:0]   int_en_r;
  logic [CNT_W-1:0]  min_r;
  logic [CNT_W-1:0]  max_r;
  logic [CNT_W-1:0]  count_r;
  logic [NUM_CH-1:0] out_inv_r;
  logic [CNT_W-1:0]  cmp_r [NUM_CH];
  logic              dir_down;
  logic              trig_r;
  logic [NUM_CH-1:0] ch_out_r;

  logic              wr_en;
  logic              rd_en;
  logic              cnt_wr;
  logic [NUM_CH-1:0] cmp_wr;
  logic [NUM_CH:0]   w1c;
  logic              tick;
  logic [CNT_W-1:0]  count_nxt;
  logic              dir_nxt;
  logic              ovf_evt;
  logic              os_stop;
  logic [NUM_CH-1:0] match_evt;

  function automatic logic hit(input logic [ADDR_W-1:0] a, input int reg_addr);
    return a == ADDR_W'(reg_addr);
  endfunction

  assign wr_en  = module_en & wr;
  assign rd_en  = module_en & ~wr;
  assign cnt_wr = wr_en & hit(addr, ADDR_COUNT);
  assign w1c    = (wr_en && hit(addr, ADDR_STATUS)) ? wdata[NUM_CH:0] : '0;

  timer_tick_gen #(.PSC_W(PSC_W)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (start_r),
    .clk_sel  (clk_sel_r),
    .psc_clr  (cnt_wr),
    .psc      (psc_r),
    .ext_tick (ext_tick),
    .tick     (tick)
  );

  // Per-channel compare register write decode
  always_comb begin
    cmp_wr = '0;
    for (int i = 0; i < NUM_CH; i++)
      cmp_wr[i] = wr_en & hit(addr, ADDR_CMP0 + i);
  end

  // Next count/direction and overflow event; a COUNT load overrides the tick
  always_comb begin
    count_nxt = count_r;
    dir_nxt   = dir_down;
    ovf_evt   = 1'b0;
    os_stop   = 1'b0;
    if (tick) begin
      case (mode_r)
        MODE_UP: begin
          if (count_r >= max_r) begin
            count_nxt = min_r;
            ovf_evt   = 1'b1;
          end else
            count_nxt = count_r + CNT_W'(1);
        end
        MODE_DOWN: begin
          if (count_r <= min_r) begin
            count_nxt = max_r;
            ovf_evt   = 1'b1;
          end else
            count_nxt = count_r - CNT_W'(1);
        end
        MODE_UPDOWN: begin
          if (!dir_down) begin
            if (count_r >= max_r) begin
              dir_nxt   = 1'b1;
              count_nxt = count_r - CNT_W'(1);
              ovf_evt   = 1'b1;
            end else
              count_nxt = count_r + CNT_W'(1);
          end else begin
            if (count_r <= min_r) begin
              dir_nxt   = 1'b0;
              count_nxt = count_r + CNT_W'(1);
            end else
              count_nxt = count_r - CNT_W'(1);
          end
        end
        MODE_ONESHOT: begin
          if (count_r >= max_r) begin
            count_nxt = max_r;
            ovf_evt   = 1'b1;
            os_stop   = 1'b1;
          end else
            count_nxt = count_r + CNT_W'(1);
        end
        default: ;
      endcase
    end
    if (cnt_wr) begin
      count_nxt = wdata;
      dir_nxt   = 1'b0;
      ovf_evt   = 1'b0;
      os_stop   = 1'b0;
    end
  end

  // Compare matches use the pre-update count; suppressed on a COUNT load
  always_comb begin
    match_evt = '0;
    for (int i = 0; i < NUM_CH; i++)
      match_evt[i] = tick & ~cnt_wr & (count_r == cmp_r[i]);
  end

  // CTRL: software write wins over the one-shot hardware stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_r   <= CTRL_RST[CTRL_START];
      mode_r    <= MODE_UP;
      clk_sel_r <= CTRL_RST[CTRL_CLK_SEL];
    end else if (wr_en && hit(addr, ADDR_CTRL)) begin
      start_r   <= wdata[CTRL_START];
      mode_r    <= mode_e'(wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
      clk_sel_r <= wdata[CTRL_CLK_SEL];
    end else if (os_stop)
      start_r <= 1'b0;
  end

  // Plain configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_r     <= '0;
      int_en_r  <= '0;
      min_r     <= '0;
      max_r     <= {CNT_W{MAX_RST_BIT}};
      out_inv_r <= '0;
      for (int i = 0; i < NUM_CH; i++)
        cmp_r[i] <= '0;
    end else begin
      if (wr_en && hit(addr, ADDR_PSC))     psc_r     <= wdata[PSC_W-1:0];
      if (wr_en && hit(addr, ADDR_INT_EN))  int_en_r  <= wdata[NUM_CH:0];
      if (wr_en && hit(addr, ADDR_MIN))     min_r     <= wdata;
      if (wr_en && hit(addr, ADDR_MAX))     max_r     <= wdata;
      if (wr_en && hit(addr, ADDR_OUT_INV)) out_inv_r <= wdata[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++)
        if (cmp_wr[i]) cmp_r[i] <= wdata;
    end
  end

  // Counter, direction, sticky flags (set beats clear) and overflow pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= '0;
      dir_down <= 1'b0;
      status_r <= '0;
      trig_r   <= 1'b0;
    end else begin
      count_r  <= count_nxt;
      dir_down <= dir_nxt;
      status_r <= (status_r & ~w1c) | {match_evt, ovf_evt};
      trig_r   <= ovf_evt;
    end
  end

  // PWM outputs, refreshed every cycle regardless of start
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ch_out_r <= '0;
    else
      for (int i = 0; i < NUM_CH; i++)
        ch_out_r[i] <= (count_r < cmp_r[i]) ^ out_inv_r[i];
  end

  // Combinational read-back; zero outside qualified reads and unmapped space
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      if (hit(addr, ADDR_CTRL))         rdata = CNT_W'({clk_sel_r, mode_r, start_r});
      else if (hit(addr, ADDR_PSC))     rdata = CNT_W'(psc_r);
      else if (hit(addr, ADDR_STATUS))  rdata = CNT_W'(status_r);
      else if (hit(addr, ADDR_INT_EN))  rdata = CNT_W'(int_en_r);
      else if (hit(addr, ADDR_MIN))     rdata = min_r;
      else if (hit(addr, ADDR_MAX))     rdata = max_r;
      else if (hit(addr, ADDR_COUNT))   rdata = count_r;
      else if (hit(addr, ADDR_OUT_INV)) rdata = CNT_W'(out_inv_r);
      else
        for (int i = 0; i < NUM_CH; i++)
          if (hit(addr, ADDR_CMP0 + i)) rdata = cmp_r[i];
    end
  end

  assign ch_out = ch_out_r;
  assign irq    = |(status_r & int_en_r);
  assign trig   = trig_r;

endmodule
